umem_arbiter: RTL and testbench

- Shares one 16-bit single-port memory between the core's instruction-fetch port and data (LSU) port.
- Each 32-bit opcode fetch becomes two sequential 16-bit reads; data accesses pass through as one transfer with byte enables.
- Sits between the core's i_mem_*/d_mem_* pins and the unified memory / external bus interface.
- Round-robin arbitration between the two ports when both request.

---
 rtl/umem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_umem_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/umem_arbiter.sv
// Shares one 16-bit single-port memory between the instruction-fetch and data ports.
// A 32-bit fetch is two sequential 16-bit reads; data accesses are single transfers.
module umem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              a_rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_flush,
  output logic [31:0]       i_opcode,
  output logic              i_rdy,
  input  logic              d_assert,
  input  logic              d_cmd,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [15:0]       d_wdata,
  input  logic              d_be0,
  input  logic              d_be1,
  output logic [15:0]       d_rdata,
  output logic              d_rdy,
  output logic              m_req,
  output logic [ADDR_W-1:0] m_addr,
  output logic [15:0]       m_wdata,
  output logic              m_we,
  output logic [1:0]        m_be,
  input  logic [15:0]       m_rdata,
  input  logic              m_ack
);
  typedef enum logic [1:0] {IDLE, I_LO, I_HI, D_ACC} state_e;

  state_e              state_q, state_d;
  logic                rr_q, rr_d;        // 1 = data port wins a tie
  logic                flush_q, flush_d;
  logic [15:0]         lo_q, lo_d;
  logic [31:0]         i_opcode_q, i_opcode_d;
  logic                i_rdy_q, i_rdy_d;
  logic [15:0]         d_rdata_q, d_rdata_d;
  logic                d_rdy_q, d_rdy_d;
  logic                m_req_q, m_req_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [15:0]         m_wdata_q, m_wdata_d;
  logic                m_we_q, m_we_d;
  logic [1:0]          m_be_q, m_be_d;

  logic d_ok, i_ok, gnt_data, gnt_fetch, flushing;

  // A request still high during its own rdy pulse is the tail of the finished access.
  assign d_ok      = d_assert & ~d_rdy_q;
  assign i_ok      = i_req & ~i_flush & ~i_rdy_q;
  assign gnt_data  = d_ok & (rr_q | ~i_ok);
  assign gnt_fetch = i_ok & ~gnt_data;
  assign flushing  = flush_q | i_flush;

  always_comb begin
    // NOTE: every _d signal gets a default first, so no branch can infer a latch.
    state_d    = state_q;
    rr_d       = rr_q;
    flush_d    = flush_q;
    lo_d       = lo_q;
    i_opcode_d = i_opcode_q;
    i_rdy_d    = 1'b0;
    d_rdata_d  = d_rdata_q;
    d_rdy_d    = 1'b0;
    m_req_d    = m_req_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_we_d     = m_we_q;
    m_be_d     = m_be_q;
    case (state_q)
      IDLE: begin
        flush_d = 1'b0;
        if (gnt_data) begin
          state_d   = D_ACC;
          rr_d      = 1'b0;
          m_req_d   = 1'b1;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          m_we_d    = d_cmd;
          m_be_d    = {d_be1, d_be0};
        end else if (gnt_fetch) begin
          state_d  = I_LO;
          rr_d     = 1'b1;
          m_req_d  = 1'b1;
          m_addr_d = i_pc;
          m_we_d   = 1'b0;
          m_be_d   = 2'b11;
        end
      end
      I_LO: begin
        flush_d = flushing;
        if (m_ack) begin
          if (flushing) begin
            state_d = IDLE;
            m_req_d = 1'b0;
            flush_d = 1'b0;
          end else begin
            lo_d     = m_rdata;
            state_d  = I_HI;
            m_addr_d = i_pc + ADDR_W'(1);
          end
        end
      end
      I_HI: begin
        flush_d = flushing;
        if (m_ack) begin
          state_d = IDLE;
          m_req_d = 1'b0;
          flush_d = 1'b0;
          if (!flushing) begin
            i_opcode_d = {m_rdata, lo_q};
            i_rdy_d    = 1'b1;
          end
        end
      end
      D_ACC: begin
        if (m_ack) begin
          state_d = IDLE;
          m_req_d = 1'b0;
          d_rdy_d = 1'b1;
          if (!m_we_q) d_rdata_d = m_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state_q    <= IDLE;
      rr_q       <= DATA_FIRST;
      flush_q    <= 1'b0;
      lo_q       <= '0;
      i_opcode_q <= '0;
      i_rdy_q    <= 1'b0;
      d_rdata_q  <= '0;
      d_rdy_q    <= 1'b0;
      m_req_q    <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_we_q     <= 1'b0;
      m_be_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      flush_q    <= flush_d;
      lo_q       <= lo_d;
      i_opcode_q <= i_opcode_d;
      i_rdy_q    <= i_rdy_d;
      d_rdata_q  <= d_rdata_d;
      d_rdy_q    <= d_rdy_d;
      m_req_q    <= m_req_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_we_q     <= m_we_d;
      m_be_q     <= m_be_d;
    end
  end

  assign i_opcode = i_opcode_q;
  assign i_rdy    = i_rdy_q;
  assign d_rdata  = d_rdata_q;
  assign d_rdy    = d_rdy_q;
  assign m_req    = m_req_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign m_we     = m_we_q;
  assign m_be     = m_be_q;

endmodule

// File: tb/tb_umem_arbiter.sv
// Bench for umem_arbiter: directed latency/flush/reset cases, then two random clients
// checked against a behavioural memory model with random wait states.
module tb_umem_arbiter;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0, a_rst = 1'b0;
  logic              i_req = 1'b0, i_flush = 1'b0, i_rdy;
  logic [ADDR_W-1:0] i_pc = '0;
  logic [31:0]       i_opcode;
  logic              d_assert = 1'b0, d_cmd = 1'b0, d_be0 = 1'b0, d_be1 = 1'b0, d_rdy;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [15:0]       d_wdata = '0, d_rdata;
  logic              m_req, m_we, m_ack = 1'b0;
  logic [ADDR_W-1:0] m_addr;
  logic [15:0]       m_wdata, m_rdata = '0;
  logic [1:0]        m_be;

  umem_arbiter #(.ADDR_W(ADDR_W), .DATA_FIRST(1'b1)) dut (
    .clk(clk), .a_rst(a_rst),
    .i_req(i_req), .i_pc(i_pc), .i_flush(i_flush), .i_opcode(i_opcode), .i_rdy(i_rdy),
    .d_assert(d_assert), .d_cmd(d_cmd), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_be0(d_be0), .d_be1(d_be1), .d_rdata(d_rdata), .d_rdy(d_rdy),
    .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_be(m_be),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Physical memory (written by the bus responder) and reference memory (written by the model).
  logic [15:0] phys [int];
  logic [15:0] ref_mem [int];

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] phys_rd(input logic [15:0] a);
    if (phys.exists(int'(a))) return phys[int'(a)];
    return init_val(a);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd,
                                        input logic [1:0] be);
    logic [15:0] r;
    r = old;
    if (be[0]) r[7:0]  = wd[7:0];
    if (be[1]) r[15:8] = wd[15:8];
    return r;
  endfunction

  task automatic set_mem(input logic [15:0] a, input logic [15:0] v);
    phys[int'(a)]    = v;
    ref_mem[int'(a)] = v;
  endtask

  // Memory responder: wait_mode >= 0 is a fixed wait, negative means random 0..3.
  int          wait_mode = 0;
  int          xfer_cnt = 0;
  int          rsp_cnt = 0;
  bit          rsp_active = 1'b0;
  logic [34:0] rsp_hold;

  always @(negedge clk) begin
    if (!a_rst || !m_req) begin
      rsp_active = 1'b0;
      m_ack      = 1'b0;
      m_rdata    = 16'($urandom);
    end else begin
      if (!rsp_active) begin
        rsp_active = 1'b1;
        xfer_cnt++;
        rsp_cnt  = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
        rsp_hold = {m_addr, m_we, m_be, m_wdata};
      end else begin
        check("m_hold", {m_addr, m_we, m_be, m_wdata}, rsp_hold);
      end
      if (rsp_cnt == 0) begin
        m_ack      = 1'b1;
        rsp_active = 1'b0;
        m_rdata    = 16'($urandom);
        if (m_we) phys[int'(m_addr)] = merge(phys_rd(m_addr), m_wdata, m_be);
        else      m_rdata = phys_rd(m_addr);
      end else begin
        rsp_cnt--;
        m_ack   = 1'b0;
        m_rdata = 16'($urandom);
      end
    end
  end

  int d_rdy_cnt = 0, i_rdy_cnt = 0;
  always @(negedge clk) begin
    if (a_rst) begin
      if (d_rdy) d_rdy_cnt++;
      if (i_rdy) i_rdy_cnt++;
      if (d_rdy || i_rdy) check("rdy_exclusive", d_rdy & i_rdy, 1'b0);
    end
  end

  logic [15:0] last_rdata;
  logic [31:0] last_op;

  task automatic check_zero(input string tag);
    check({tag, "_i"}, {i_opcode, i_rdy, d_rdy}, '0);
    check({tag, "_m"}, {d_rdata, m_req, m_addr, m_wdata, m_we, m_be}, '0);
  endtask

  task automatic do_reset();
    i_req = 0; i_flush = 0; i_pc = '0;
    d_assert = 0; d_cmd = 0; d_addr = '0; d_wdata = '0; d_be0 = 0; d_be1 = 0;
    a_rst = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    a_rst = 1'b1;
    @(negedge clk);
    last_rdata = '0;
    last_op    = '0;
  endtask

  task automatic data_access(input bit cmd, input logic [15:0] addr, input logic [15:0] wd,
                             input logic [1:0] be, input bit hold_tail);
    bit seen;
    seen = 1'b0;
    d_cmd = cmd; d_addr = addr; d_wdata = wd; {d_be1, d_be0} = be; d_assert = 1'b1;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      seen = d_rdy;
    end
    check("d_done", seen, 1'b1);
    if (seen) begin
      if (cmd) begin
        check("d_wr_keep", d_rdata, last_rdata);
        ref_mem[int'(addr)] = merge(ref_rd(addr), wd, be);
      end else begin
        last_rdata = ref_rd(addr);
        check("d_rd", d_rdata, last_rdata);
      end
    end
    if (hold_tail) @(negedge clk);
    d_assert = 1'b0;
  endtask

  task automatic fetch(input logic [15:0] pc, input bit hold_tail);
    bit          seen;
    logic [15:0] pc1;
    seen = 1'b0;
    pc1  = pc + 16'd1;
    i_pc = pc; i_req = 1'b1;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      seen = i_rdy;
    end
    check("i_done", seen, 1'b1);
    if (seen) begin
      last_op = {ref_rd(pc1), ref_rd(pc)};
      check("i_op", i_opcode, last_op);
    end
    if (hold_tail) @(negedge clk);
    i_req = 1'b0;
  endtask

  function automatic logic [15:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 9));
    return (r < 2) ? 16'(16'hFFFE + r) : 16'(r - 2);
  endfunction

  int  got, extra, x0, d0, i0;
  bit  exp_data, seen;

  initial begin
    // Data read, zero wait: m_req at T+1, d_rdy at T+2.
    do_reset();
    wait_mode = 0;
    set_mem(16'h0100, 16'hBEEF);
    d_cmd = 0; d_addr = 16'h0100; d_be0 = 1; d_be1 = 1; d_assert = 1;
    @(negedge clk);
    check("t1_mreq", {m_req, m_we, d_rdy}, 3'b100);
    check("t1_maddr", m_addr, 16'h0100);
    @(negedge clk);
    check("t1_drdy", d_rdy, 1'b1);
    check("t1_rdata", d_rdata, 16'hBEEF);
    last_rdata = 16'hBEEF;
    d_assert = 0;
    @(negedge clk);
    check("t1_tail_ignored", {d_rdy, m_req}, 2'b00);

    // Fetch across the address wrap: lo at T+1, hi at T+2, i_rdy at T+3.
    set_mem(16'hFFFF, 16'h1234);
    set_mem(16'h0000, 16'hABCD);
    i_pc = 16'hFFFF; i_req = 1;
    @(negedge clk);
    check("t2_lo", {m_req, m_we, m_be, m_addr}, {1'b1, 1'b0, 2'b11, 16'hFFFF});
    @(negedge clk);
    check("t2_hi", {m_req, i_rdy, m_addr}, {1'b1, 1'b0, 16'h0000});
    @(negedge clk);
    check("t2_irdy", i_rdy, 1'b1);
    check("t2_op", i_opcode, 32'hABCD1234);
    last_op = 32'hABCD1234;
    i_req = 0;
    @(negedge clk);
    check("t2_idle", {i_rdy, m_req}, 2'b00);

    // Both ports held from reset: grants alternate, data first.
    do_reset();
    wait_mode = -1;
    d_cmd = 0; d_addr = 16'h0200; d_be0 = 1; d_be1 = 1; i_pc = 16'h0300;
    d_assert = 1; i_req = 1;
    got = 0; exp_data = 1'b1;
    for (int c = 0; c < 400 && got < 8; c++) begin
      @(negedge clk);
      if (d_rdy || i_rdy) begin
        check("t3_order", d_rdy, exp_data);
        if (d_rdy) check("t3_rdata", d_rdata, ref_rd(16'h0200));
        else       check("t3_op", i_opcode, {ref_rd(16'h0301), ref_rd(16'h0300)});
        exp_data = ~exp_data;
        got++;
      end
    end
    d_assert = 0; i_req = 0;
    check("t3_grants", got, 8);
    last_rdata = ref_rd(16'h0200);
    last_op    = {ref_rd(16'h0301), ref_rd(16'h0300)};
    repeat (6) @(negedge clk);
    check("t3_quiet", m_req, 1'b0);

    // High-byte write with three wait states: bus held four cycles, one d_rdy.
    wait_mode = 3;
    set_mem(16'h0400, 16'h1234);
    d_cmd = 1; d_be1 = 1; d_be0 = 0; d_wdata = 16'h5500; d_addr = 16'h0400; d_assert = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t4_hold", {m_req, m_we, m_be, m_addr, m_wdata},
            {1'b1, 1'b1, 2'b10, 16'h0400, 16'h5500});
      check("t4_nordy", d_rdy, 1'b0);
    end
    @(negedge clk);
    check("t4_drdy", d_rdy, 1'b1);
    check("t4_rdata_kept", d_rdata, last_rdata);
    ref_mem[32'h0400] = merge(ref_rd(16'h0400), 16'h5500, 2'b10);
    d_assert = 0;
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (d_rdy) extra++;
    end
    check("t4_single_rdy", extra, 0);
    wait_mode = 0;
    data_access(1'b0, 16'h0400, 16'h0000, 2'b11, 1'b0);
    check("t4_readback", d_rdata, 16'h5534);

    // Flush during the high half: transfer completes, no i_rdy, opcode kept.
    repeat (2) @(negedge clk);
    wait_mode = 3;
    x0 = xfer_cnt;
    i_pc = 16'h0500; i_req = 1;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = m_req && (m_addr == 16'h0501);
    end
    check("t5_hi_seen", seen, 1'b1);
    i_flush = 1; i_req = 0;
    @(negedge clk);
    i_flush = 0;
    extra = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (i_rdy) extra++;
    end
    check("t5_no_irdy", extra, 0);
    check("t5_op_kept", i_opcode, last_op);
    check("t5_xfers", xfer_cnt - x0, 2);
    check("t5_idle", m_req, 1'b0);
    wait_mode = -1;
    fetch(16'h0600, 1'b0);

    // Flush during the low half: one transfer only, back to IDLE.
    repeat (2) @(negedge clk);
    wait_mode = 2;
    x0 = xfer_cnt;
    i_pc = 16'h0700; i_req = 1;
    @(negedge clk);
    i_flush = 1; i_req = 0;
    @(negedge clk);
    i_flush = 0;
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (i_rdy) extra++;
    end
    check("t6_no_irdy", extra, 0);
    check("t6_xfers", xfer_cnt - x0, 1);
    check("t6_op_kept", i_opcode, last_op);

    // Flush in IDLE blocks the fetch grant.
    x0 = xfer_cnt;
    i_pc = 16'h0800; i_req = 1; i_flush = 1;
    repeat (3) @(negedge clk);
    check("t7_blocked", {m_req, 16'(xfer_cnt - x0)}, '0);
    i_flush = 0;
    wait_mode = 0;
    fetch(16'h0800, 1'b0);

    // Asynchronous reset while a data access is waiting on the bus.
    @(negedge clk);
    wait_mode = 5;
    d_cmd = 0; d_addr = 16'h0010; d_be0 = 1; d_be1 = 1; d_assert = 1;
    @(negedge clk);
    check("t8_mreq", m_req, 1'b1);
    #2 a_rst = 0;
    #1 check_zero("t8_async");
    d_assert = 0;
    @(negedge clk);
    a_rst = 1;
    last_rdata = '0; last_op = '0;
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (d_rdy || i_rdy || m_req) extra++;
    end
    check("t8_no_spurious", extra, 0);

    // Random traffic from both ports against the reference memory.
    wait_mode = -1;
    d0 = d_rdy_cnt; i0 = i_rdy_cnt;
    fork
      for (int k = 0; k < 60; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        data_access(1'($urandom), rand_addr(), 16'($urandom), 2'($urandom_range(0, 3)),
                    1'($urandom));
      end
      for (int k = 0; k < 60; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        fetch(rand_addr(), 1'($urandom));
      end
    join
    repeat (5) @(negedge clk);
    check("rnd_drdy_cnt", d_rdy_cnt - d0, 60);
    check("rnd_irdy_cnt", i_rdy_cnt - i0, 60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule
